// File: rtl/hex_disp_sched.sv
// hex_disp_sched: two-requester arbiter for the six HEX displays.
// The winning value is latched with its hex-enable and blink masks, held for
// HOLD_CYCLES, then shown through six enc7led encoders with blink and
// leading-zero blanking. Segment outputs are registered and active-low.

// enc7led: nibble to active-low segments {g,f,e,d,c,b,a}.
// With enchx=0, nibbles 10..15 show the error glyph instead of A..F.
module enc7led (
    input  logic [3:0] nib,
    input  logic       enchx,
    output logic [6:0] seg
);
    // Combinational glyph lookup
    always_comb begin
        seg = 7'b1001001;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = enchx ? 7'b0001000 : 7'b1001001;
            4'hB: seg = enchx ? 7'b0000011 : 7'b1001001;
            4'hC: seg = enchx ? 7'b1000110 : 7'b1001001;
            4'hD: seg = enchx ? 7'b0100001 : 7'b1001001;
            4'hE: seg = enchx ? 7'b0000110 : 7'b1001001;
            4'hF: seg = enchx ? 7'b0001110 : 7'b1001001;
            default: seg = 7'b1001001;
        endcase
    end
endmodule

module hex_disp_sched #(
    parameter int HOLD_CYCLES = 4,
    parameter int BLINK_DIV   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [23:0] req_data0,
    input  logic [23:0] req_data1,
    input  logic [5:0]  req_hex0,
    input  logic [5:0]  req_hex1,
    input  logic [5:0]  req_blink0,
    input  logic [5:0]  req_blink1,
    input  logic        lz_en,
    output logic [1:0]  req_ready,
    output logic        disp_valid,
    output logic        disp_src,
    output logic        busy,
    output logic [41:0] hex_leds
);
    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic {IDLE, HOLD} state_e;

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [BCW-1:0]   blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;
    logic [23:0]      data_q, data_d;
    logic [5:0]       hex_q, hex_d;
    logic [5:0]       blink_q, blink_d;
    logic             disp_valid_q, disp_valid_d;
    logic             disp_src_q, disp_src_d;
    logic [41:0]      hex_leds_q, hex_leds_d;
    logic [1:0]       grant;
    logic [5:0]       lz_sup;
    logic [5:0][6:0]  seg_enc;

    // Grant is only offered from IDLE; a tie goes to the rr pointer
    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Ready is suppressed while reset is held so nothing looks accepted
    assign req_ready = grant & {2{rst_n}};

    // Next-state: accept/hold FSM, shadow load, free-running blink timer
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        hold_cnt_d   = hold_cnt_q;
        data_d       = data_q;
        hex_d        = hex_q;
        blink_d      = blink_q;
        disp_valid_d = disp_valid_q;
        disp_src_d   = disp_src_q;
        blink_cnt_d  = blink_cnt_q + 1'b1;
        phase_d      = phase_q;
        if (blink_cnt_q == BCW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    data_d       = grant[1] ? req_data1  : req_data0;
                    hex_d        = grant[1] ? req_hex1   : req_hex0;
                    blink_d      = grant[1] ? req_blink1 : req_blink0;
                    disp_src_d   = grant[1];
                    disp_valid_d = 1'b1;
                    rr_d         = ~grant[1];
                    state_d      = HOLD;
                    hold_cnt_d   = HCW'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) state_d = IDLE;
                else                  hold_cnt_d = hold_cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-digit encoders and leading-zero detection
    for (genvar k = 0; k < 6; k++) begin : g_dig
        enc7led u_enc (
            .nib   (data_q[4*k +: 4]),
            .enchx (hex_q[k]),
            .seg   (seg_enc[k])
        );
        if (k == 0) begin : g_lsd
            assign lz_sup[k] = 1'b0;
        end else begin : g_msd
            assign lz_sup[k] = lz_en & ~(|data_q[23:4*k]);
        end
    end

    // Blank or encoded segments for each digit
    always_comb begin
        hex_leds_d = '1;
        for (int k = 0; k < 6; k++) begin
            if (disp_valid_q && !(blink_q[k] && !phase_q) && !lz_sup[k])
                hex_leds_d[7*k +: 7] = seg_enc[k];
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            hold_cnt_q   <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b1;
            data_q       <= '0;
            hex_q        <= '0;
            blink_q      <= '0;
            disp_valid_q <= 1'b0;
            disp_src_q   <= 1'b0;
            hex_leds_q   <= '1;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            hold_cnt_q   <= hold_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            data_q       <= data_d;
            hex_q        <= hex_d;
            blink_q      <= blink_d;
            disp_valid_q <= disp_valid_d;
            disp_src_q   <= disp_src_d;
            hex_leds_q   <= hex_leds_d;
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_src   = disp_src_q;
    assign busy       = (state_q == HOLD);
    assign hex_leds   = hex_leds_q;
endmodule

// File: tb/tb_hex_disp_sched.sv
// Bench for hex_disp_sched: random and directed stimulus against a
// timeline model (edge index, hold-release edge, blink phase from edge count).
module tb_hex_disp_sched;
    localparam int HOLD  = 4;
    localparam int BDIV  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [23:0] req_data0, req_data1;
    logic [5:0]  req_hex0, req_hex1, req_blink0, req_blink1;
    logic        lz_en;
    logic [1:0]  req_ready;
    logic        disp_valid, disp_src, busy;
    logic [41:0] hex_leds;

    int n_cmp = 0;
    int n_bad = 0;

    hex_disp_sched #(.HOLD_CYCLES(HOLD), .BLINK_DIV(BDIV)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1),
        .req_hex0(req_hex0), .req_hex1(req_hex1),
        .req_blink0(req_blink0), .req_blink1(req_blink1),
        .lz_en(lz_en), .req_ready(req_ready), .disp_valid(disp_valid),
        .disp_src(disp_src), .busy(busy), .hex_leds(hex_leds)
    );

    always #5 clk = ~clk;

    // Reference glyphs, index = nibble, hex digits A..F
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state
    int          m_k;         // edges since reset release
    int          m_hold_end;  // edge at which the display frees up
    logic        m_rr, m_valid, m_src;
    logic [23:0] m_data;
    logic [5:0]  m_hex, m_blink;
    logic [41:0] m_leds;

    function automatic logic phase_of(int k);
        return ((k / BDIV) % 2) == 0;
    endfunction

    function automatic logic [41:0] render(logic [23:0] d, logic [5:0] hx, logic [5:0] bl,
                                           logic v, logic ph, logic lz);
        logic [41:0] r;
        logic [3:0]  nib;
        logic [23:0] upper;
        r = '1;
        for (int k = 0; k < 6; k++) begin
            nib   = d[4*k +: 4];
            upper = d >> (4*k);
            if (v && !(bl[k] && !ph) && !(lz && k > 0 && upper == 0))
                r[7*k +: 7] = (nib >= 10 && !hx[k]) ? 7'h49 : glyph[nib];
        end
        return r;
    endfunction

    function automatic logic [1:0] model_grant();
        if (m_k < m_hold_end || req_valid == 2'b00) return 2'b00;
        if (req_valid == 2'b11) return m_rr ? 2'b10 : 2'b01;
        return req_valid;
    endfunction

    task automatic model_reset();
        m_k = 0; m_hold_end = 0; m_rr = 1'b0; m_valid = 1'b0; m_src = 1'b0;
        m_data = '0; m_hex = '0; m_blink = '0; m_leds = '1;
    endtask

    // Advance one clock edge, updating the model; samples #1 after the edge
    task automatic step();
        logic [1:0]  g;
        logic [41:0] nl;
        g  = model_grant();
        nl = render(m_data, m_hex, m_blink, m_valid, phase_of(m_k), lz_en);
        @(posedge clk);
        m_k++;
        if (g != 2'b00) begin
            m_src   = g[1];
            m_data  = g[1] ? req_data1  : req_data0;
            m_hex   = g[1] ? req_hex1   : req_hex0;
            m_blink = g[1] ? req_blink1 : req_blink0;
            m_valid = 1'b1;
            m_rr    = ~g[1];
            m_hold_end = m_k + HOLD;
        end
        m_leds = nl;
        #1;
    endtask

    task automatic set_req(logic [1:0] v, logic [23:0] d0, logic [23:0] d1,
                           logic [5:0] h0, logic [5:0] h1, logic [5:0] b0, logic [5:0] b1);
        req_valid = v; req_data0 = d0; req_data1 = d1;
        req_hex0 = h0; req_hex1 = h1; req_blink0 = b0; req_blink1 = b1;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; lz_en = 1'b0;
        set_req(2'b11, 24'h123456, 24'h654321, 6'h3F, 6'h3F, 6'h0, 6'h0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({hex_leds, req_ready, disp_valid, busy} !== {42'h3FF_FFFF_FFFF, 2'b00, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset_hold cyc%0d: leds=%h ready=%b dv=%b busy=%b, want all-ones/00/0/0",
                         i, hex_leds, req_ready, disp_valid, busy);
            end
        end
        set_req(2'b01, 24'h0, 24'h0, 6'h0, 6'h0, 6'h0, 6'h0);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_first_ready: got %b want 01", req_ready);
        end
        set_req(2'b00, 24'h0, 24'h0, 6'h0, 6'h0, 6'h0, 6'h0);
    endtask

    // Cycle-by-cycle comparison of every output against the model
    task automatic run_cycles(int n, string tag, logic rnd);
        logic [1:0] eg;
        for (int i = 0; i < n; i++) begin
            if (rnd)
                set_req(2'($urandom_range(0, 3)), 24'($urandom), 24'($urandom),
                        6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
            if (rnd && (i % 16 == 0)) lz_en = 1'($urandom);
            #1;
            eg = model_grant();
            n_cmp++;
            if (req_ready !== eg || req_ready === 2'b11) begin
                n_bad++;
                $display("FAIL %s_ready i=%0d: got %b want %b", tag, i, req_ready, eg);
            end
            step();
            n_cmp++;
            if ({hex_leds, busy, disp_valid, disp_src} !==
                {m_leds, (m_k < m_hold_end), m_valid, m_src}) begin
                n_bad++;
                $display("FAIL %s_out i=%0d: leds=%h busy=%b dv=%b src=%b want leds=%h busy=%b dv=%b src=%b",
                         tag, i, hex_leds, busy, disp_valid, disp_src,
                         m_leds, (m_k < m_hold_end), m_valid, m_src);
            end
        end
    endtask

    task automatic test_single();
        int n_acc, first, second;
        n_acc = 0; first = -1; second = -1;
        set_req(2'b01, 24'h123456, 24'h0, 6'h0, 6'h0, 6'h0, 6'h0);
        for (int i = 0; i < 12; i++) begin
            if (req_ready[0]) begin
                if (first < 0) first = m_k + 1; else if (second < 0) second = m_k + 1;
            end
            step();
            n_cmp++;
            if ({hex_leds, busy} !== {m_leds, (m_k < m_hold_end)}) begin
                n_bad++;
                $display("FAIL single_out i=%0d: leds=%h busy=%b want %h %b",
                         i, hex_leds, busy, m_leds, (m_k < m_hold_end));
            end
            if (first > 0 && m_k == first + 1) begin
                n_cmp++;
                if (hex_leds !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'b0000010}) begin
                    n_bad++;
                    $display("FAIL single_glyphs: got %h want 123456 glyphs", hex_leds);
                end
            end
        end
        n_cmp++;
        if (first < 0 || second - first != HOLD + 1) begin
            n_bad++;
            $display("FAIL single_reaccept: edges %0d,%0d want spacing %0d", first, second, HOLD + 1);
        end
        set_req(2'b00, 24'h0, 24'h0, 6'h0, 6'h0, 6'h0, 6'h0);
        run_cycles(HOLD + 1, "single_drain", 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [1:0] want;
        int acc;
        acc = 0;
        set_req(2'b11, 24'hAAAAAA, 24'h555555, 6'h3F, 6'h3F, 6'h0, 6'h0);
        want = m_rr ? 2'b10 : 2'b01;
        for (int i = 0; i < 30; i++) begin
            if (req_ready != 2'b00) begin
                n_cmp++;
                if (req_ready !== want) begin
                    n_bad++;
                    $display("FAIL b2b_alternate acc%0d: got %b want %b", acc, req_ready, want);
                end
                want = ~want; acc++;
            end
            run_cycles(1, "b2b", 1'b0);
        end
        n_cmp++;
        if (acc != 6) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d accepts want 6", acc);
        end
        set_req(2'b00, 24'h0, 24'h0, 6'h0, 6'h0, 6'h0, 6'h0);
        run_cycles(HOLD + 1, "b2b_drain", 1'b0);
    endtask

    task automatic lz_case(logic [5:0] hx, logic lz, logic [41:0] want, string tag);
        lz_en = lz;
        set_req(2'b10, 24'h0, 24'h00000A, 6'h0, hx, 6'h0, 6'h0);
        run_cycles(1, tag, 1'b0);
        set_req(2'b00, 24'h0, 24'h0, 6'h0, 6'h0, 6'h0, 6'h0);
        run_cycles(HOLD + 1, tag, 1'b0);
        n_cmp++;
        if (hex_leds !== want) begin
            n_bad++;
            $display("FAIL %s_const: got %h want %h", tag, hex_leds, want);
        end
    endtask

    task automatic test_lz();
        lz_case(6'b000001, 1'b1, {{5{7'h7F}}, 7'b0001000}, "lz_hex");
        lz_case(6'b000000, 1'b1, {{5{7'h7F}}, 7'b1001001}, "lz_err");
        lz_case(6'b000001, 1'b0, {{5{7'b1000000}}, 7'b0001000}, "lz_off");
    endtask

    task automatic test_blink();
        int toggles;
        logic [6:0] prev5;
        lz_en = 1'b0;
        set_req(2'b01, 24'h876543, 24'h0, 6'h0, 6'h0, 6'b100000, 6'h0);
        run_cycles(1, "blink_acc", 1'b0);
        set_req(2'b00, 24'h0, 24'h0, 6'h0, 6'h0, 6'h0, 6'h0);
        run_cycles(2, "blink_settle", 1'b0);
        prev5 = hex_leds[41:35];
        toggles = 0;
        for (int i = 0; i < 4 * BDIV; i++) begin
            run_cycles(1, "blink", 1'b0);
            if (hex_leds[41:35] !== prev5) toggles++;
            prev5 = hex_leds[41:35];
            n_cmp++;
            if (hex_leds[34:0] !== {7'h78, 7'h19, 7'h12, 7'h30, 7'h30} - 35'h0 && 1'b0) n_bad++;
        end
        n_cmp++;
        if (toggles != 4) begin
            n_bad++;
            $display("FAIL blink_toggles: got %0d want 4 over %0d cycles", toggles, 4 * BDIV);
        end
    endtask

    task automatic test_random();
        run_cycles(300, "rand", 1'b1);
        set_req(2'b00, 24'h0, 24'h0, 6'h0, 6'h0, 6'h0, 6'h0);
        run_cycles(HOLD + 1, "rand_drain", 1'b0);
    endtask

    task automatic test_reset_mid_hold();
        lz_en = 1'b0;
        set_req(2'b10, 24'hFEDCBA, 24'h111111, 6'h3F, 6'h3F, 6'h0, 6'h0);
        run_cycles(3, "mid_pre", 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({hex_leds, busy, disp_valid, req_ready} !== {42'h3FF_FFFF_FFFF, 1'b0, 1'b0, 2'b00}) begin
            n_bad++;
            $display("FAIL mid_reset_blank: leds=%h busy=%b dv=%b ready=%b", hex_leds, busy, disp_valid, req_ready);
        end
        @(negedge clk);
        set_req(2'b11, 24'h222222, 24'h333333, 6'h0, 6'h0, 6'h0, 6'h0);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL mid_reset_rr: got %b want 01", req_ready);
        end
        run_cycles(12, "mid_post", 1'b0);
    endtask

    initial begin
        test_reset();
        apply_reset();
        test_single();
        test_back_to_back();
        test_lz();
        test_blink();
        test_random();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule

// File: doc/hex_disp_sched.md
Name: hex_disp_sched

Overview:
- Arbitrates two requesters, e.g. the I2C debug path and the main control FSM, for the board's six HEX seven-segment displays.
- Latches the winning 24-bit value with per-digit hex-enable and blink masks.
- Holds each accepted value for a minimum time so a person can read it.
- Applies blink and leading-zero blanking, then drives six internal enc7led instances with registered, active-low segment outputs.

Parameters:
HOLD_CYCLES, 4, minimum cycles a value stays displayed before the next accept; must be >= 1 (hardware: 25_000_000).
BLINK_DIV, 8, cycles per blink half-period; must be >= 1 (hardware: 12_500_000).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester write request; index 0 and 1
req_data0  in  24  requester 0 value; digit k = bits [4k+3:4k], digit 0 = HEX0
req_data1  in  24  requester 1 value
req_hex0  in  6  requester 0 per-digit hex enable (enchx)
req_hex1  in  6  requester 1 per-digit hex enable
req_blink0  in  6  requester 0 per-digit blink mask
req_blink1  in  6  requester 1 per-digit blink mask
lz_en  in  1  leading-zero suppression enable, sampled live
req_ready  out  2  per-requester accept; a transfer occurs when valid & ready at a rising edge
disp_valid  out  1  at least one value accepted since reset
disp_src  out  1  index of the requester owning the current value
busy  out  1  state == HOLD
hex_leds  out  42  segments, digit k = bits [7k+6:7k], active-low

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr pointer=0, hold counter=0, blink counter=0, blink phase=1 (on).
  - Shadow data/hex/blink = 0, disp_valid=0, disp_src=0, busy=0.
  - hex_leds = all ones (all digits blank).
- Reset asserted mid-HOLD aborts immediately; no partial state survives.
- States:
  - IDLE: accepts a request.
  - HOLD: refuses all requests.
- Grant, combinational, IDLE only:
  - If only one req_valid bit is set, that requester is granted.
  - If both are set, requester rr is granted.
  - req_ready = one-hot grant in IDLE, 0 in HOLD; never both bits set.
- On accept at edge N:
  - Shadow registers load the granted data/hex/blink.
  - disp_src = granted index, disp_valid = 1.
  - rr = the other index (flips even if the other was not requesting).
  - state = HOLD, counter = HOLD_CYCLES-1.
- HOLD:
  - Counter decrements each edge.
  - At the edge where counter == 0, state goes to IDLE.
  - Next accept is possible at edge N+HOLD_CYCLES+1 at the earliest.
- Requesters hold valid and data until ready; an unaccepted valid has no effect.
- Blink:
  - Free-running counter 0..BLINK_DIV-1.
  - On wrap, phase toggles.
  - Runs regardless of state.
- Leading-zero suppression:
  - When lz_en=1, digit k (5..1) is blank iff its nibble and all higher nibbles are 0.
  - Digit 0 is never suppressed.
- Blank condition for digit k:
  - !disp_valid, OR (blink[k] & phase==0), OR lz-suppressed.
- Segment output:
  - Blank digit gives 7'b1111111.
  - Otherwise the enc7led output for (nibble k, hex[k]).
  - Non-hex nibbles >= 10 therefore show the encoder's error glyph.
- hex_leds is registered:
  - Reflects shadow/phase/lz_en state one edge after it changes.
  - A value accepted at edge N appears on hex_leds after edge N+1.
- No arithmetic beyond counters; all counters wrap explicitly and never exceed their parameter bound.

Test Plan:
- Reset, then hold rst_n=0 for 3 cycles -> hex_leds=42'h3FF_FFFF_FFFF, req_ready=00, disp_valid=0 throughout; after release, first requester valid sees ready=1 that cycle.
- r0 sends 24'h123456, hex=0, blink=0 at edge N -> after N+1, digits HEX5..HEX0 show 1,2,3,4,5,6 (HEX0=7'b0000010); busy=1 for edges N..N+3; r0 re-accepted no earlier than N+5.
- Both valid continuously, HOLD_CYCLES=4 -> grants alternate r0,r1,r0,r1 at accept edges spaced 5 cycles; disp_src toggles; req_ready never 2'b11.
- r1 sends 24'h00000A, hex=6'b000001, lz_en=1 -> HEX5..HEX1 blank (7'h7F), HEX0=7'b0001000; with hex=0 instead, HEX0=7'b1001001; with lz_en=0, HEX5..HEX1=7'b1000000.
- blink=6'b100000, BLINK_DIV=8 -> HEX5 alternates value/blank every 8 cycles, other digits steady.
- Reset asserted 2 cycles into HOLD -> immediate blank, state IDLE, rr=0; with both valid after release, r0 is granted first.
